// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for the arbiter: fetch port, data port and the single memory port.
// slave is the arbiter's view; master is the requester/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [DATA_W-1:0] if_rdata;
   logic              if_ready;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              stall_if;
   logic              stall_mem;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ready, d_rdata, d_ready,
      output mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ready, d_rdata, d_ready,
      input  mem_en, mem_we, mem_addr, mem_wdata, stall_if, stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous single-ported memory between a fetch port and a data port.
// Data has priority, but fetch wins once it has been deferred MAX_DEFER grants in a row.
module mem_port_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 2,
   parameter int MAX_DEFER   = 2
) (
   input logic               clk,
   input logic               reset,
   mem_port_arbiter_if.slave bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);
   localparam logic [2:0] DEFER_MAX = 3'(MAX_DEFER);

   state_t            state_q, state_d;
   logic              owner_q, owner_d;      // 1 = data port, 0 = fetch port
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [2:0]        defer_q, defer_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              mem_en_q, mem_en_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              if_ready_q, if_ready_d;
   logic              d_ready_q, d_ready_d;
   logic              grant_data;
   logic              grant_fetch;

   assign grant_data  = bus.d_req && (!bus.if_req || (defer_q != DEFER_MAX));
   assign grant_fetch = bus.if_req && !grant_data;

   // Transaction FSM: arbitration, latching of the winner, busy countdown, read capture.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      defer_d    = defer_q;
      if_rdata_d = if_rdata_q;
      d_rdata_d  = d_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_data) begin
               state_d = BUSY;
               owner_d = 1'b1;
               we_d    = bus.d_we;
               addr_d  = bus.d_addr;
               wdata_d = bus.d_wdata;
               cnt_d   = WAIT_LD;
               if (bus.if_req && (defer_q != DEFER_MAX)) begin
                  defer_d = defer_q + 3'd1;
               end else begin
                  defer_d = defer_q;
               end
            end else if (grant_fetch) begin
               state_d = BUSY;
               owner_d = 1'b0;
               we_d    = 1'b0;
               addr_d  = bus.if_addr;
               wdata_d = {DATA_W{1'b0}};
               cnt_d   = WAIT_LD;
               defer_d = 3'd0;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (cnt_q <= 4'd1) begin
               state_d = RESP;
               cnt_d   = 4'd0;
               // Writes complete without touching the data-side read register.
               if (!owner_q) begin
                  if_rdata_d = bus.mem_rdata;
               end else if (!we_q) begin
                  d_rdata_d = bus.mem_rdata;
               end else begin
                  d_rdata_d = d_rdata_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs, decoded from the next state.
   always_comb begin
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = {ADDR_W{1'b0}};
      mem_wdata_d = {DATA_W{1'b0}};
      if_ready_d  = 1'b0;
      d_ready_d   = 1'b0;
      if (state_d == BUSY) begin
         mem_en_d    = 1'b1;
         mem_addr_d  = addr_d;
         mem_wdata_d = wdata_d;
         mem_we_d    = (state_q == IDLE) ? we_d : 1'b0;
      end else if (state_d == RESP) begin
         if_ready_d = ~owner_d;
         d_ready_d  = owner_d;
      end else begin
         mem_en_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         owner_q     <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= {ADDR_W{1'b0}};
         wdata_q     <= {DATA_W{1'b0}};
         cnt_q       <= 4'd0;
         defer_q     <= 3'd0;
         if_rdata_q  <= {DATA_W{1'b0}};
         d_rdata_q   <= {DATA_W{1'b0}};
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         if_ready_q  <= 1'b0;
         d_ready_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cnt_q       <= cnt_d;
         defer_q     <= defer_d;
         if_rdata_q  <= if_rdata_d;
         d_rdata_q   <= d_rdata_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_ready_q  <= if_ready_d;
         d_ready_q   <= d_ready_d;
      end
   end

   assign bus.if_rdata  = if_rdata_q;
   assign bus.if_ready  = if_ready_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_ready   = d_ready_q;
   assign bus.mem_en    = mem_en_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.stall_if  = bus.if_req & ~if_ready_q;
   assign bus.stall_mem = bus.d_req & ~d_ready_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (WAIT_CYCLES=2, MAX_DEFER=2); completions are
// checked by a scoreboard monitor, bus-level details by inline checks.
module tb_mem_port_arbiter;
   logic clk;
   logic reset;
   logic use_fixed;
   logic [15:0] fixed_val;
   int checks;
   int errors;
   int edge_cnt;

   typedef struct {
      logic        owner;
      logic [15:0] rdata;
      int          edge_n;
   } exp_t;
   exp_t sb_q[$];

   mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

   mem_port_arbiter #(
      .ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2), .MAX_DEFER(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   assign bus.mem_rdata = use_fixed ? fixed_val : (bus.mem_addr ^ 16'hA5A5);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic owner, input logic [15:0] rdata, input int edge_n);
      exp_t e;
      e.owner  = owner;
      e.rdata  = rdata;
      e.edge_n = edge_n;
      sb_q.push_back(e);
   endtask

   // Monitor: every completion pulse must match the next expected response.
   always @(negedge clk) begin
      if (bus.if_ready || bus.d_ready) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: if_ready=%b d_ready=%b at edge %0d", bus.if_ready, bus.d_ready, edge_cnt);
         end else begin
            exp_t e;
            logic [15:0] got;
            e = sb_q.pop_front();
            got = bus.d_ready ? bus.d_rdata : bus.if_rdata;
            if ((bus.if_ready && bus.d_ready) || (bus.d_ready != e.owner) || (got !== e.rdata) || (edge_cnt != e.edge_n)) begin
               errors++;
               $display("FAIL completion: got owner=%b data=%h edge=%0d expected owner=%b data=%h edge=%0d",
                        bus.d_ready, got, edge_cnt, e.owner, e.rdata, e.edge_n);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int e0;
      checks = 0;
      errors = 0;
      edge_cnt = 0;
      reset = 1'b0;
      use_fixed = 1'b0;
      fixed_val = 16'h0000;
      bus.if_req = 1'b0;
      bus.if_addr = 16'h0000;
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      bus.d_addr = 16'h0000;
      bus.d_wdata = 16'h0000;

      // Reset state
      step(2);
      @(negedge clk);
      chk("reset_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
      chk("reset_mem_ctl", {30'd0, bus.mem_en, bus.mem_we}, 32'd0);
      chk("reset_mem_bus", {bus.mem_addr, bus.mem_wdata}, 32'd0);
      chk("reset_rdata", {bus.if_rdata, bus.d_rdata}, 32'd0);
      chk("reset_stall", {30'd0, bus.stall_if, bus.stall_mem}, 32'd0);
      step(1);
      reset = 1'b1;
      step(1);

      // Fetch-only read
      use_fixed = 1'b1;
      fixed_val = 16'hABCD;
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0010;
      e0 = edge_cnt;
      push(1'b0, 16'hABCD, e0 + 3);
      @(negedge clk);
      chk("fetch_c0_stall_if", {31'd0, bus.stall_if}, 32'd1);
      chk("fetch_c0_mem_en", {31'd0, bus.mem_en}, 32'd0);
      step(1);
      @(negedge clk);
      chk("fetch_c1_mem_en", {31'd0, bus.mem_en}, 32'd1);
      chk("fetch_c1_mem_we", {31'd0, bus.mem_we}, 32'd0);
      chk("fetch_c1_addr", {16'd0, bus.mem_addr}, 32'h0010);
      step(1);
      @(negedge clk);
      chk("fetch_c2_mem_en", {31'd0, bus.mem_en}, 32'd1);
      chk("fetch_c2_stall_if", {31'd0, bus.stall_if}, 32'd1);
      step(1);
      @(negedge clk);
      chk("fetch_c3_stall_if", {31'd0, bus.stall_if}, 32'd0);
      chk("fetch_c3_mem_idle", {15'd0, bus.mem_en, bus.mem_addr}, 32'd0);
      step(1);
      bus.if_req = 1'b0;
      @(negedge clk);
      chk("fetch_rdata_hold", {16'd0, bus.if_rdata}, 32'hABCD);
      step(1);

      // Data write, inputs changed after grant
      bus.d_req = 1'b1;
      bus.d_we = 1'b1;
      bus.d_addr = 16'h0040;
      bus.d_wdata = 16'h1234;
      e0 = edge_cnt;
      push(1'b1, 16'h0000, e0 + 3);
      @(negedge clk);
      chk("write_c0_stall_mem", {31'd0, bus.stall_mem}, 32'd1);
      step(1);
      bus.d_addr = 16'h9999;
      bus.d_wdata = 16'hFFFF;
      @(negedge clk);
      chk("write_c1_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd3);
      chk("write_c1_bus", {bus.mem_addr, bus.mem_wdata}, 32'h0040_1234);
      step(1);
      @(negedge clk);
      chk("write_c2_we", {30'd0, bus.mem_en, bus.mem_we}, 32'd2);
      chk("write_c2_bus", {bus.mem_addr, bus.mem_wdata}, 32'h0040_1234);
      step(2);
      bus.d_req = 1'b0;
      bus.d_we = 1'b0;
      step(1);

      // Both requesters held: data, data, fetch, data, data, fetch
      use_fixed = 1'b0;
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0100;
      bus.d_req = 1'b1;
      bus.d_addr = 16'h0200;
      e0 = edge_cnt;
      push(1'b1, 16'hA7A5, e0 + 3);
      push(1'b1, 16'hA7A5, e0 + 7);
      push(1'b0, 16'hA4A5, e0 + 11);
      push(1'b1, 16'hA7A5, e0 + 15);
      push(1'b1, 16'hA7A5, e0 + 19);
      push(1'b0, 16'hA4A5, e0 + 23);
      step(23);
      bus.if_req = 1'b0;
      bus.d_req = 1'b0;
      step(2);

      // Reset during the second BUSY cycle of a read
      bus.d_req = 1'b1;
      bus.d_addr = 16'h0300;
      step(2);
      @(negedge clk);
      chk("abort_busy_mem_en", {31'd0, bus.mem_en}, 32'd1);
      reset = 1'b0;
      bus.d_req = 1'b0;
      step(1);
      @(negedge clk);
      chk("abort_ready", {30'd0, bus.if_ready, bus.d_ready}, 32'd0);
      chk("abort_mem", {14'd0, bus.mem_en, bus.mem_we, bus.mem_addr}, 32'd0);
      chk("abort_rdata", {bus.if_rdata, bus.d_rdata}, 32'd0);
      chk("abort_stall", {30'd0, bus.stall_if, bus.stall_mem}, 32'd0);
      step(1);
      // Request present on the first edge with reset released
      reset = 1'b1;
      bus.d_req = 1'b1;
      e0 = edge_cnt;
      push(1'b1, 16'hA6A5, e0 + 3);
      step(3);
      bus.d_req = 1'b0;
      step(1);

      // Fetch drops its request mid-transaction while data arrives
      bus.if_req = 1'b1;
      bus.if_addr = 16'h0400;
      e0 = edge_cnt;
      push(1'b0, 16'hA1A5, e0 + 3);
      push(1'b1, 16'hA0A5, e0 + 7);
      step(1);
      bus.if_req = 1'b0;
      bus.d_req = 1'b1;
      bus.d_addr = 16'h0500;
      @(negedge clk);
      chk("drop_stall_mem", {31'd0, bus.stall_mem}, 32'd1);
      chk("drop_busy_addr", {16'd0, bus.mem_addr}, 32'h0400);
      step(6);
      bus.d_req = 1'b0;
      step(3);

      chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory data width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, memory read latency in cycles; legal range 1..15.
REQ-004 SHALL have parameter MAX_DEFER, default 2, consecutive data grants tolerated while fetch waits; legal range 1..7.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-007 SHALL have ports if_req input 1 fetch request; if_addr input ADDR_W fetch address; if_rdata output DATA_W fetch data; if_ready output 1 fetch completion pulse.
REQ-008 SHALL have ports d_req input 1 data request; d_we input 1 write enable; d_addr input ADDR_W; d_wdata input DATA_W; d_rdata output DATA_W; d_ready output 1 data completion pulse.
REQ-009 SHALL have ports mem_en output 1; mem_we output 1; mem_addr output ADDR_W; mem_wdata output DATA_W; mem_rdata input DATA_W (synchronous single-ported memory).
REQ-010 SHALL have ports stall_if output 1 and stall_mem output 1, pipeline stall requests.

Function
REQ-011 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-012 IDLE: on an edge with if_req or d_req high, SHALL latch winner's address, wdata, we (we=0 for fetch), record owner, load cycle counter with WAIT_CYCLES, go to BUSY; otherwise stay IDLE.
REQ-013 Arbitration: data SHALL win when both request, unless defer count equals MAX_DEFER, in which case fetch SHALL win.
REQ-014 Defer count SHALL increment (saturating at MAX_DEFER) on each data grant with if_req high, clear to 0 on each fetch grant, and hold otherwise.
REQ-015 BUSY: mem_en SHALL be 1, mem_addr/mem_wdata SHALL drive latched values, mem_we SHALL be latched we only in the first BUSY cycle (single write per transaction).
REQ-016 BUSY SHALL last exactly WAIT_CYCLES cycles; on the edge ending the last BUSY cycle, mem_rdata SHALL be captured into the owner's rdata register and FSM SHALL go to RESP.
REQ-017 RESP: owner's ready SHALL be 1 for exactly one cycle, other ready 0, mem_en 0; FSM SHALL return to IDLE (no grant from RESP).
REQ-018 Latency: request sampled at edge 0 SHALL yield ready high in cycle WAIT_CYCLES+1; minimum spacing between grants is WAIT_CYCLES+2 cycles.
REQ-019 if_rdata/d_rdata SHALL hold their last captured value until the next completion for that owner; writes SHALL not update d_rdata.
REQ-020 Requesters hold req/addr/wdata until ready; changes to inputs after grant SHALL not affect the transaction in progress.
REQ-021 If owner drops req mid-transaction, transaction SHALL still complete and ready SHALL still pulse.
REQ-022 stall_if SHALL equal if_req AND NOT if_ready; stall_mem SHALL equal d_req AND NOT d_ready (combinational).
REQ-023 mem_en, mem_we SHALL be 0 in IDLE and RESP; mem_addr/mem_wdata SHALL be 0 outside BUSY.

Reset
REQ-024 On any edge with reset=0, FSM SHALL go to IDLE, defer count, counter, owner, if_rdata, d_rdata SHALL clear to 0, regardless of state.
REQ-025 After reset edge all outputs SHALL be 0 (stall_* follow REQ-022 with ready=0).
REQ-026 Reset mid-BUSY SHALL abort the transaction: no ready pulse, mem_en 0 from the next cycle, no further write.
REQ-027 First grant SHALL be possible on the first edge with reset=1.

Verification (WAIT_CYCLES=2, MAX_DEFER=2)
REQ-028 Fetch only: if_req=1, if_addr=0x0010, mem_rdata=0xABCD during BUSY -> mem_en high cycles 1-2, if_ready pulse cycle 3, if_rdata=0xABCD, stall_if high cycles 0-2.
REQ-029 Data write: d_req=1, d_we=1, d_addr=0x0040, d_wdata=0x1234 -> mem_we=1 only first BUSY cycle with addr 0x0040, d_ready pulse cycle 3, d_rdata unchanged.
REQ-030 Simultaneous held requests -> grant order data, data, fetch, data, data, fetch; each ready pulse separated by 4 cycles.
REQ-031 Reset=0 during second BUSY cycle of a read -> no ready pulse, mem_en 0 next cycle, all outputs 0; new request after release completes normally.
REQ-032 Fetch drops if_req in first BUSY cycle while d_req rises -> if_ready still pulses in RESP; data granted from following IDLE cycle.
